deserializer: RTL and testbench
===============================

// Module: deserializer
// PURPOSE
// - Serial-to-parallel receiver for a 10-bit (8b/10b-coded) line: samples a_rx once per clk, MSB first.
// - Emits each 10-bit symbol on c_parallel_out with a valid flag and a divide-by-10 word clock.
// - Computes the running disparity of each received symbol.
// - Sits between the serial line front end and the 10b/8b decoder.
// - Optional K28.5 comma detection realigns the word boundary.
// PARAMETERS
// - WORD_W        10  symbol width (fixed at 10 for 8b/10b; other values not supported)
// - COMMA_ALIGN   1   1 = realign word boundary on K28.5; 0 = free-running framing from reset
// PORTS
// - clk             in   1   sole clock; all logic on posedge
// - rst             in   1   synchronous, active-high reset
// - a_rx            in   1   serial data bit, sampled every posedge clk
// - disparity_d     in   1   running disparity before current symbol (0 = RD-, 1 = RD+)
// - c_parallel_out  out  10  last complete symbol; first-received bit in [9]
// - clk_out         out  1   word clock, clk/10, 50% duty
// - disparity_q     out  1   running disparity after the symbol in c_parallel_out
// - c_data_valid    out  1   high while c_parallel_out holds a complete symbol
// BEHAVIOUR
// - Reset: sr, bit_cnt, c_parallel_out, clk_out, disparity_q and c_data_valid all go to 0 on the rst edge.
//   - rst overrides all other activity.
//   - Reset mid-symbol discards the partial symbol.
// - Bit capture
//   - Each non-reset edge: sr <= {sr[8:0], a_rx}.
//   - bit_cnt counts 0..9; the first edge after reset samples bit 0.
// - Word latch: on the edge where bit_cnt==9, with window w = {sr[8:0], a_rx}:
//   - c_parallel_out <= w
//   - c_data_valid <= 1
//   - bit_cnt <= 0
// - Latency: the word is visible at the outputs immediately after the edge sampling its 10th bit.
// - c_data_valid
//   - Stays 1 after the first word and returns to 0 only on rst.
//   - c_parallel_out holds its value until the next latch.
// - Disparity, computed at each latch from the popcount of w:
//   - ones > 5  -> disparity_q <= 1
//   - ones < 5  -> disparity_q <= 0
//   - ones == 5 -> disparity_q <= disparity_d
//   - disparity_q changes only at a latch.
// - clk_out: registered; 1 while bit_cnt is in 0..4 and 0 while it is in 5..9.
//   - It is therefore 1 on the cycle following a latch.
//   - It is 0 during reset.
// - Comma alignment (COMMA_ALIGN=1)
//   - Trigger: on any edge where w == 10'b0011111010 or w == 10'b1100000101.
//   - Action: latch w as a word (same rules as above) and set bit_cnt <= 0, regardless of the current count.
//   - A comma that coincides with bit_cnt==9 is a single ordinary latch; there is no double latch.
// - No data-dependent stalls; one bit is consumed every clk cycle.
// STRUCTURE
// - Package deser_pkg:
//   - WORD_W
//   - K28P5_RDN = 10'b0011111010
//   - K28P5_RDP = 10'b1100000101
//   - function rd_next(word, rd_in) implementing the disparity rule
// - Sub-module deser_rd_calc: combinational popcount plus rd_next.
// - Top level holds the shift register, bit counter, comma compare and output registers.
// TESTING
// - Reset: assert rst 2 cycles -> c_parallel_out=0, c_data_valid=0, clk_out=0, disparity_q=0.
// - Basic word:
//   - Stimulus: COMMA_ALIGN=0, rst released, bits 1,0,1,0,1,1,0,0,1,1 on 10 consecutive edges.
//   - Response: c_parallel_out=10'b1010110011 and c_data_valid=1 after the 10th edge.
//   - Response: 6 ones -> disparity_q=1.
// - Balanced word:
//   - Stimulus: 10'b1010101010 with disparity_d=1, then with disparity_d=0.
//   - Response: disparity_q=1, then 0.
//   - Stimulus: 10'b0000011000 -> Response: disparity_q=0.
// - Comma realign:
//   - Stimulus: 3 arbitrary bits, then 0011111010.
//   - Response: latch at the comma's last bit, c_parallel_out=10'b0011111010.
//   - Response: the next word latches exactly 10 edges later.
// - Word clock: continuous stream -> clk_out period = 10 clk, 5 high / 5 low, rising the cycle after each latch.
// - Mid-word reset:
//   - Stimulus: rst for 1 cycle after 4 bits.
//   - Response: outputs cleared, c_data_valid=0.
//   - Response: the next word is framed from the first post-reset bit.

Source files
------------

// File: rtl/deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deser_pkg
// Description : Shared constants and the running-disparity rule for the
//               10-bit (8b/10b) serial-to-parallel receiver.
//               Contents:
//                 WORD_W     - symbol width (10)
//                 K28P5_RDN  - K28.5 comma as sent from RD-
//                 K28P5_RDP  - K28.5 comma as sent from RD+
//                 rd_next()  - running disparity after a symbol
// Revision    : 1.0 - initial release
// ============================================================================
package deser_pkg;

    localparam int WORD_W = 10;

    localparam logic [WORD_W-1:0] K28P5_RDN = 10'b0011111010;
    localparam logic [WORD_W-1:0] K28P5_RDP = 10'b1100000101;

    // More ones than zeros leaves the line RD+, fewer leaves it RD-,
    // and a balanced symbol carries the incoming disparity through.
    function automatic logic rd_next(input logic [WORD_W-1:0] word,
                                     input logic              rd_in);
        int ones;
        ones = 0;
        for (int i = 0; i < WORD_W; i++) begin
            ones = ones + {31'd0, word[i]};
        end
        if (ones > WORD_W / 2) begin
            return 1'b1;
        end else if (ones < WORD_W / 2) begin
            return 1'b0;
        end else begin
            return rd_in;
        end
    endfunction

endpackage : deser_pkg
`default_nettype wire

// File: rtl/deser_rd_calc.sv
`default_nettype none
// ============================================================================
// Module      : deser_rd_calc
// Description : Combinational running-disparity calculation for one symbol.
// Ports       : word   in  10  candidate symbol
//               rd_in  in  1   running disparity before the symbol
//               rd_out out 1   running disparity after the symbol
// Revision    : 1.0 - initial release
// ============================================================================
module deser_rd_calc
    import deser_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic              rd_in,
    output logic              rd_out
);

    always_comb begin
        rd_out = rd_next(word, rd_in);
    end

endmodule : deser_rd_calc
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Serial-to-parallel receiver for a 10-bit 8b/10b line.
//               Samples one bit per clk (MSB first), presents each complete
//               symbol with a sticky valid flag, its running disparity and a
//               divide-by-10 word clock. Optional K28.5 comma realignment.
// Parameters  : COMMA_ALIGN 1 = realign framing on K28.5, 0 = free-running
// Ports       : clk            in  1   clock, rising edge
//               rst            in  1   synchronous active-high reset
//               a_rx           in  1   serial data bit
//               disparity_d    in  1   running disparity before the symbol
//               c_parallel_out out 10  last complete symbol, first bit in [9]
//               clk_out        out 1   word clock, clk/10, 50% duty
//               disparity_q    out 1   running disparity after the symbol
//               c_data_valid   out 1   a complete symbol has been captured
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer
    import deser_pkg::*;
#(
    parameter bit COMMA_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_rx,
    input  logic              disparity_d,
    output logic [WORD_W-1:0] c_parallel_out,
    output logic              clk_out,
    output logic              disparity_q,
    output logic              c_data_valid
);

    localparam logic [3:0] C_LAST_BIT = 4'd9;
    localparam logic [3:0] C_HALF     = 4'd5;

    // Only the previous nine bits need storing: the tenth is a_rx itself,
    // so the full window is available on the same edge it completes.
    logic [WORD_W-2:0] r_sr;
    logic [3:0]        r_bit_cnt;

    logic [WORD_W-1:0] w_window;
    logic              w_comma;
    logic              w_latch;
    logic [3:0]        w_cnt_next;
    logic              w_rd_next;

    always_comb begin
        w_window = {r_sr, a_rx};
        w_comma  = COMMA_ALIGN &&
                   ((w_window == K28P5_RDN) || (w_window == K28P5_RDP));
        // A comma landing on the tenth bit is the same single latch.
        w_latch  = (r_bit_cnt == C_LAST_BIT) || w_comma;
        if (w_latch) begin
            w_cnt_next = 4'd0;
        end else begin
            w_cnt_next = r_bit_cnt + 4'd1;
        end
    end

    deser_rd_calc u_rd_calc (
        .word   (w_window),
        .rd_in  (disparity_d),
        .rd_out (w_rd_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr           <= '0;
            r_bit_cnt      <= 4'd0;
            c_parallel_out <= '0;
            clk_out        <= 1'b0;
            disparity_q    <= 1'b0;
            c_data_valid   <= 1'b0;
        end else begin
            r_sr      <= w_window[WORD_W-2:0];
            r_bit_cnt <= w_cnt_next;
            // Word clock follows the count it is about to hold, so it is
            // high on the cycle right after every latch.
            clk_out   <= (w_cnt_next < C_HALF);
            if (w_latch) begin
                c_parallel_out <= w_window;
                c_data_valid   <= 1'b1;
                disparity_q    <= w_rd_next;
            end
        end
    end

endmodule : deserializer
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer
// Description : Self-checking bench for deserializer. Drives a free-running
//               instance (COMMA_ALIGN=0) and an aligning instance
//               (COMMA_ALIGN=1) from the same serial stream and compares both
//               every cycle against a bit-queue reference model; directed
//               sequences pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

    localparam logic [9:0] C_K_RDN = 10'b0011111010;
    localparam logic [9:0] C_K_RDP = 10'b1100000101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_rx = 1'b0;
    logic       disparity_d = 1'b0;

    logic [9:0] po0, po1;
    logic       co0, co1, rq0, rq1, dv0, dv1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    deserializer #(.COMMA_ALIGN(1'b0)) u_free (
        .clk            (clk),
        .rst            (rst),
        .a_rx           (a_rx),
        .disparity_d    (disparity_d),
        .c_parallel_out (po0),
        .clk_out        (co0),
        .disparity_q    (rq0),
        .c_data_valid   (dv0)
    );

    deserializer #(.COMMA_ALIGN(1'b1)) u_align (
        .clk            (clk),
        .rst            (rst),
        .a_rx           (a_rx),
        .disparity_d    (disparity_d),
        .c_parallel_out (po1),
        .clk_out        (co1),
        .disparity_q    (rq1),
        .c_data_valid   (dv1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the last ten line bits (zeros before any data),
    // the number of bits received since the current word boundary, and
    // the expected output registers. Index 0 = free-running, 1 = aligning.
    // ------------------------------------------------------------------
    logic [9:0] m_win   [2];
    int         m_n     [2];
    logic [9:0] m_word  [2];
    logic       m_valid [2];
    logic       m_rd    [2];
    logic       m_clk   [2];
    bit         m_live = 1'b0;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_win[m]   = '0;
                m_n[m]     = 0;
                m_word[m]  = '0;
                m_valid[m] = 1'b0;
                m_rd[m]    = 1'b0;
                m_clk[m]   = 1'b0;
            end else begin
                m_win[m] = {m_win[m][8:0], a_rx};
                m_n[m]   = m_n[m] + 1;
                if (m_n[m] == 10 ||
                    (m == 1 && (m_win[m] == C_K_RDN || m_win[m] == C_K_RDP))) begin
                    m_word[m]  = m_win[m];
                    m_valid[m] = 1'b1;
                    if ($countones(m_win[m]) > 5)      m_rd[m] = 1'b1;
                    else if ($countones(m_win[m]) < 5) m_rd[m] = 1'b0;
                    else                               m_rd[m] = disparity_d;
                    m_n[m] = 0;
                end
                m_clk[m] = (m_n[m] < 5);
            end
        end
        m_live = 1'b1;
    end

    // Every-cycle comparison, one time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (m_live) begin
            chk("free word",  {22'd0, po0}, {22'd0, m_word[0]});
            chk("free valid", {31'd0, dv0}, {31'd0, m_valid[0]});
            chk("free rd",    {31'd0, rq0}, {31'd0, m_rd[0]});
            chk("free clk",   {31'd0, co0}, {31'd0, m_clk[0]});
            chk("algn word",  {22'd0, po1}, {22'd0, m_word[1]});
            chk("algn valid", {31'd0, dv1}, {31'd0, m_valid[1]});
            chk("algn rd",    {31'd0, rq1}, {31'd0, m_rd[1]});
            chk("algn clk",   {31'd0, co1}, {31'd0, m_clk[1]});
        end
    end

    // Stimulus tasks are entered and left at a falling edge.
    task automatic send(input logic b);
        a_rx = b;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) send(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst word",  {22'd0, po0}, 32'd0);
        chk("rst valid", {31'd0, dv0}, 32'd0);
        chk("rst clk",   {31'd0, co0}, 32'd0);
        chk("rst rd",    {31'd0, rq0}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] w;
        int r;
        @(negedge clk);

        // Basic word, 6 ones -> RD+
        do_reset();
        send_word(10'b1010110011);
        chk("basic word",  {22'd0, po0}, 32'h2B3);
        chk("basic valid", {31'd0, dv0}, 32'd1);
        chk("basic rd",    {31'd0, rq0}, 32'd1);
        chk("model basic", {22'd0, m_word[0]}, 32'h2B3);

        // Balanced words carry disparity_d through; light word forces RD-
        disparity_d = 1'b1;
        send_word(10'b1010101010);
        chk("bal rd+", {31'd0, rq0}, 32'd1);
        disparity_d = 1'b0;
        send_word(10'b1010101010);
        chk("bal rd-", {31'd0, rq0}, 32'd0);
        disparity_d = 1'b1;
        send_word(10'b0000011000);
        chk("light rd",   {31'd0, rq0}, 32'd0);
        chk("light word", {22'd0, po0}, 32'h018);
        chk("model light rd", {31'd0, m_rd[0]}, 32'd0);

        // Comma realign on the aligning instance
        do_reset();
        send(1'b1); send(1'b0); send(1'b1);
        send_word(C_K_RDN);
        chk("comma word", {22'd0, po1}, {22'd0, C_K_RDN});
        chk("comma clk",  {31'd0, co1}, 32'd1);
        chk("model comma", {22'd0, m_word[1]}, 32'h0FA);
        w = 10'b1010101010;
        for (int i = 9; i >= 1; i--) send(w[i]);
        chk("comma hold", {22'd0, po1}, {22'd0, C_K_RDN});
        send(w[0]);
        chk("after comma", {22'd0, po1}, 32'h2AA);

        // Mid-word reset discards the partial word
        do_reset();
        send(1'b1); send(1'b1); send(1'b1); send(1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst valid", {31'd0, dv0}, 32'd0);
        chk("midrst word",  {22'd0, po0}, 32'd0);
        rst = 1'b0;
        w = 10'b1100110101;
        for (int i = 9; i >= 1; i--) send(w[i]);
        chk("midrst early", {31'd0, dv0}, 32'd0);
        send(w[0]);
        chk("midrst frame", {22'd0, po0}, 32'h335);

        // Randomised stream with injected commas and rare resets
        for (int k = 0; k < 3000; k++) begin
            disparity_d = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if (r < 6) begin
                send_word(r[0] ? C_K_RDN : C_K_RDP);
            end else begin
                send(1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_deserializer
`default_nettype wire
